mult_booth: RTL

- Sequential signed 32x32 multiplier implementing MIPS `mult`. Radix-2 Booth, one step per clock.
- Sits directly downstream of the A/B operand registers and upstream of the HI/LO source muxes.
- The control unit pulses `start`, waits for `done`, then asserts HILOWrite with HISrc/LOSrc selecting this unit.

---
 rtl/mult_booth_pkg.sv | 19 +
 rtl/mult_booth_step.sv | 33 +++
 rtl/mult_booth.sv | 102 ++++++++++
 3 files changed

// File: rtl/mult_booth_pkg.sv
// Shared sequencing definitions for the iterative multiply/divide units.
// The IDLE/RUN/DONE encoding and the latency constant are used by the control unit.
package mult_booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    localparam int unsigned MULT_WIDTH   = 32;
    // Cycles from the start-sampling IDLE cycle back to IDLE.
    localparam int unsigned MULT_LATENCY = MULT_WIDTH + 2;

    function automatic int unsigned mult_latency(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of m into acc,
// then an arithmetic right shift of {acc, q, q_m1} by one bit.
module mult_booth_step
    import mult_booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_m1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_m1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q_m1})
            2'b01:   w_sum = i_acc + i_m;
            2'b10:   w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    // acc is WIDTH+1 bits, so its MSB is a true sign bit even for m = -2^(WIDTH-1).
    assign o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q_m1 = i_q[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTHxWIDTH multiplier (MIPS mult), one Booth step per clock.
// Holds the last product on hi_out/lo_out until the next one completes.
module mult_booth
    import mult_booth_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    mult_state_e r_state, w_state_next;

    logic [WIDTH:0]   r_acc, r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_q_m1;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic [WIDTH:0]   w_acc_n;
    logic [WIDTH-1:0] w_q_n;
    logic             w_q_m1_n;
    logic             w_last;

    mult_booth_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .i_m    (r_m),
        .o_acc  (w_acc_n),
        .o_q    (w_q_n),
        .o_q_m1 (w_q_m1_n)
    );

    assign w_last = (r_count == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m     <= {a_in[WIDTH-1], a_in};
                        r_acc   <= '0;
                        r_q     <= b_in;
                        r_q_m1  <= 1'b0;
                        r_count <= CW'(WIDTH);
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_n;
                    r_q     <= w_q_n;
                    r_q_m1  <= w_q_m1_n;
                    r_count <= r_count - CW'(1);
                    // Publish the product on the same edge that enters DONE.
                    if (w_last) begin
                        r_hi <= w_acc_n[WIDTH-1:0];
                        r_lo <= w_q_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);

endmodule
